// File: rtl/x_clk_div.sv
// Multi-channel programmable clock-enable generator: per-channel tick and optional square wave.
// Define X_CLK_DIV_SQUARE_EN to build the o_clk square-wave outputs; otherwise o_clk is tied low.
module x_clk_div #(
  parameter int p_channels = 4,
  parameter int p_width    = 8,
  parameter int p_init_div = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic [p_channels-1:0] i_en,
  input  logic                  i_cfg_valid,
  output logic                  o_cfg_ready,
  input  logic [((p_channels > 1) ? $clog2(p_channels) : 1)-1:0] i_cfg_ch,
  input  logic [p_width-1:0]    i_cfg_div,
  output logic [p_channels-1:0] o_busy,
  output logic [p_channels-1:0] o_tick,
  output logic [p_channels-1:0] o_clk
);

  localparam int p_chw = (p_channels > 1) ? $clog2(p_channels) : 1;
  localparam logic [p_width-1:0] one_c = 1;
  localparam logic [p_width:0]   one_w = 1;

  logic xfer;

  // Channel numbers beyond p_channels see ready=1 and the request is dropped.
  always_comb begin
    o_cfg_ready = 1'b1;
    for (int c = 0; c < p_channels; c++) begin
      if (i_cfg_ch == p_chw'(c)) o_cfg_ready = ~o_busy[c];
    end
  end

  assign xfer = i_cfg_valid && o_cfg_ready;

  genvar c;
  generate
    for (c = 0; c < p_channels; c++) begin : g_ch
      logic [p_width-1:0] cnt_q;
      logic [p_width-1:0] div_q;
      logic [p_width-1:0] pend_div_q;
      logic               pend_q;
      logic               tick_q;
      logic               active;
      logic               wrap;
      logic               apply;
      logic               sel;
      logic [p_width-1:0] cnt_nxt;
      logic [p_width-1:0] div_nxt;

      assign active  = i_en[c] && (div_q != '0);
      assign wrap    = active && (cnt_q == (div_q - one_c));
      // Pending ratios land only on a period boundary or while idle.
      assign apply   = pend_q && (wrap || !active);
      assign sel     = xfer && (i_cfg_ch == p_chw'(c));
      assign cnt_nxt = (active && !wrap) ? (cnt_q + one_c) : '0;
      assign div_nxt = apply ? pend_div_q : div_q;

      always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
          cnt_q      <= '0;
          div_q      <= p_width'(p_init_div);
          pend_div_q <= '0;
          pend_q     <= 1'b0;
          tick_q     <= 1'b0;
        end else begin
          cnt_q  <= cnt_nxt;
          div_q  <= div_nxt;
          tick_q <= wrap;
          // A transfer needs pend_q=0, so it never collides with an apply.
          if (sel) begin
            pend_q     <= 1'b1;
            pend_div_q <= i_cfg_div;
          end else if (apply) begin
            pend_q <= 1'b0;
          end
        end
      end

      assign o_tick[c] = tick_q;
      assign o_busy[c] = pend_q;

`ifdef X_CLK_DIV_SQUARE_EN
      logic [p_width:0] half;
      logic             clk_q;

      // Evaluated against the ratio that governs the next cycle; D=0 gives half=0.
      assign half = ({1'b0, div_nxt} + one_w) >> 1;

      always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
          clk_q <= 1'b0;
        end else begin
          clk_q <= active && ({1'b0, cnt_nxt} < half);
        end
      end

      assign o_clk[c] = clk_q;
`else
      assign o_clk[c] = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_x_clk_div.sv
// Directed bench for x_clk_div: tick edges are queued per channel up front and matched by a
// negedge monitor; busy/ready/clk levels are checked at fixed edges by the stimulus process.
module tb_x_clk_div;

  logic       clk = 1'b0;
  logic       nrst;
  logic [3:0] en;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [7:0] cfg_div;
  logic [3:0] busy;
  logic [3:0] tick;
  logic [3:0] dclk;

  int n_chk  = 0;
  int n_pass = 0;
  int e      = -1;
  int s      = 1000000;
  int exp_q [4][$];

`ifdef X_CLK_DIV_SQUARE_EN
  localparam bit sq_en = 1'b1;
`else
  localparam bit sq_en = 1'b0;
`endif

  x_clk_div dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_en        (en),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_ch    (cfg_ch),
    .i_cfg_div   (cfg_div),
    .o_busy      (busy),
    .o_tick      (tick),
    .o_clk       (dclk)
  );

  always #5 clk = ~clk;
  always @(posedge clk) e <= e + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at edge %0d: got %0h want %0h", nm, e - s, act, exp);
  endtask

  task automatic push_per(input int ch, input int first, input int step, input int last);
    for (int r = first; r <= last; r += step) exp_q[ch].push_back(s + r);
  endtask

  task automatic to_edge(input int r);
    while (e < s + r) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: every tick must match the head of its channel's queue.
  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      while (exp_q[c].size() > 0 && exp_q[c][0] < e) begin
        n_chk++;
        $display("FAIL tick_ch%0d: tick=0 at edge %0d, want tick=1", c, exp_q[c][0] - s);
        void'(exp_q[c].pop_front());
      end
      if (tick[c] === 1'b1) begin
        n_chk++;
        if (exp_q[c].size() > 0 && exp_q[c][0] == e) begin
          n_pass++;
          void'(exp_q[c].pop_front());
        end else begin
          $display("FAIL tick_ch%0d: tick=1 at edge %0d, want tick=0", c, e - s);
        end
      end
    end
  end

  initial begin
    nrst = 1'b0; en = 4'h0; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_div = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_clk", 32'(dclk), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h1);

    s = e + 1;
    nrst = 1'b1;
    en   = 4'hF;
    push_per(0, 3, 4, 31);  push_per(0, 39, 4, 47);
    push_per(1, 3, 4, 11);  push_per(1, 18, 5, 33); push_per(1, 39, 4, 47);
    push_per(2, 3, 4, 23);  push_per(2, 32, 3, 32); push_per(2, 39, 4, 47);
    push_per(3, 3, 4, 15);  push_per(3, 16, 1, 33); push_per(3, 39, 4, 47);

    // D=4: square wave 2 high / 2 low, counter at (r+1)%4 after edge r
    for (int r = 0; r <= 5; r++) begin
      to_edge(r);
      chk("clk4_ch0", 32'(dclk[0]), (sq_en && ((r + 1) % 4) < 2) ? 32'h1 : 32'h0);
    end
    to_edge(6);
    chk("clk4_ch0", 32'(dclk[0]), 32'h0);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd7;

    to_edge(7);
    chk("clk4_ch0", 32'(dclk[0]), sq_en ? 32'h1 : 32'h0);
    chk("busy_after_xfer", 32'(busy), 32'h2);
    cfg_valid = 1'b0; cfg_ch = 2'd2;
    #1;
    chk("ready_other_ch", 32'(cfg_ready), 32'h1);

    to_edge(8);
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 8'd5;
    #1;
    chk("ready_busy_ch1", 32'(cfg_ready), 32'h0);
    to_edge(9);
    chk("ready_busy_ch1", 32'(cfg_ready), 32'h0);
    to_edge(10);
    chk("ready_busy_ch1", 32'(cfg_ready), 32'h0);
    chk("busy1_held", 32'(busy), 32'h2);
    to_edge(11);
    chk("busy1_fall", 32'(busy), 32'h0);
    chk("ready_after_fall", 32'(cfg_ready), 32'h1);
    to_edge(12);
    chk("busy1_second", 32'(busy), 32'h2);
    cfg_valid = 1'b0;

    to_edge(13);
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd1;
    to_edge(14);
    cfg_valid = 1'b0;
    chk("busy_1_3", 32'(busy), 32'hA);
    to_edge(15);
    chk("busy_1_only", 32'(busy), 32'h2);

    for (int r = 16; r <= 22; r++) begin
      to_edge(r);
      if (r <= 19) chk("clk1_ch3", 32'(dclk[3]), sq_en ? 32'h1 : 32'h0);
      if (r >= 18) chk("clk5_ch1", 32'(dclk[1]), (sq_en && r <= 20) ? 32'h1 : 32'h0);
      if (r == 18) chk("busy_clear", 32'(busy), 32'h0);
      if (r == 19) begin
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd0;
      end
      if (r == 20) begin
        cfg_valid = 1'b0;
        chk("busy_ch2_d0", 32'(busy), 32'h4);
      end
    end

    to_edge(23);
    chk("busy_d0_applied", 32'(busy), 32'h0);
    to_edge(24);
    chk("d0_tick", 32'(tick[2]), 32'h0);
    chk("d0_clk", 32'(dclk[2]), 32'h0);
    to_edge(25);
    en[2] = 1'b0;
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd3;
    to_edge(26);
    cfg_valid = 1'b0;
    chk("idle_busy_on", 32'(busy), 32'h4);
    to_edge(27);
    chk("idle_busy_off", 32'(busy), 32'h0);
    to_edge(29);
    en[2] = 1'b1;

    to_edge(32);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd6;
    to_edge(33);
    cfg_valid = 1'b0; cfg_ch = 2'd0;
    chk("busy_ch0_pend", 32'(busy), 32'h1);
    nrst = 1'b0;
    to_edge(34);
    chk("mid_rst_tick", 32'(tick), 32'h0);
    chk("mid_rst_clk", 32'(dclk), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_ready", 32'(cfg_ready), 32'h1);
    to_edge(35);
    nrst = 1'b1;

    to_edge(48);
    en = 4'h0;
    to_edge(49);
    chk("dis_tick", 32'(tick), 32'h0);
    chk("dis_clk", 32'(dclk), 32'h0);

    to_edge(52);
    for (int c = 0; c < 4; c++) chk($sformatf("tick_q_empty_ch%0d", c), 32'(exp_q[c].size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
